// File: rtl/se_api_reg_responder_pkg.sv
// Message field widths and command codes shared by the register responder,
// mirroring the SciEngines API constant set.
package se_api_reg_responder_pkg;

  localparam int C_LENGTH_SLOT = 4;
  localparam int C_LENGTH_FPGA = 4;
  localparam int C_LENGTH_REG  = 8;
  localparam int C_LENGTH_CMD  = 8;
  localparam int C_LENGTH_DATA = 32;

  localparam logic [C_LENGTH_CMD-1:0] CMD_REG_WR   = 8'd0;
  localparam logic [C_LENGTH_CMD-1:0] CMD_REG_RD   = 8'd1;
  localparam logic [C_LENGTH_CMD-1:0] CMD_REG_RESP = 8'd2;

  typedef struct packed {
    logic [C_LENGTH_SLOT-1:0] src_slot;
    logic [C_LENGTH_FPGA-1:0] src_fpga;
    logic [C_LENGTH_REG-1:0]  src_reg;
    logic [C_LENGTH_CMD-1:0]  src_cmd;
    logic [C_LENGTH_REG-1:0]  tgt_reg;
    logic [C_LENGTH_CMD-1:0]  tgt_cmd;
    logic [C_LENGTH_DATA-1:0] data;
  } api_msg_t;

endpackage

// File: rtl/se_api_reg_responder_if.sv
// API message port bundle: the FWFT input FIFO head plus the response output port.
interface se_api_reg_responder_if;
  import se_api_reg_responder_pkg::*;

  logic                     api_i_empty;
  logic                     api_i_rd_en;
  logic [C_LENGTH_SLOT-1:0] api_i_src_slot;
  logic [C_LENGTH_FPGA-1:0] api_i_src_fpga;
  logic [C_LENGTH_REG-1:0]  api_i_src_reg;
  logic [C_LENGTH_CMD-1:0]  api_i_src_cmd;
  logic [C_LENGTH_REG-1:0]  api_i_tgt_reg;
  logic [C_LENGTH_CMD-1:0]  api_i_tgt_cmd;
  logic [C_LENGTH_DATA-1:0] api_i_data;

  logic                     api_o_rfd;
  logic                     api_o_wr_en;
  logic [C_LENGTH_SLOT-1:0] api_o_tgt_slot;
  logic [C_LENGTH_FPGA-1:0] api_o_tgt_fpga;
  logic [C_LENGTH_REG-1:0]  api_o_tgt_reg;
  logic [C_LENGTH_CMD-1:0]  api_o_tgt_cmd;
  logic [C_LENGTH_REG-1:0]  api_o_src_reg;
  logic [C_LENGTH_CMD-1:0]  api_o_src_cmd;
  logic [C_LENGTH_DATA-1:0] api_o_data;

  modport master (
    output api_i_empty, api_i_src_slot, api_i_src_fpga, api_i_src_reg, api_i_src_cmd,
           api_i_tgt_reg, api_i_tgt_cmd, api_i_data, api_o_rfd,
    input  api_i_rd_en, api_o_wr_en, api_o_tgt_slot, api_o_tgt_fpga, api_o_tgt_reg,
           api_o_tgt_cmd, api_o_src_reg, api_o_src_cmd, api_o_data
  );

  modport slave (
    input  api_i_empty, api_i_src_slot, api_i_src_fpga, api_i_src_reg, api_i_src_cmd,
           api_i_tgt_reg, api_i_tgt_cmd, api_i_data, api_o_rfd,
    output api_i_rd_en, api_o_wr_en, api_o_tgt_slot, api_o_tgt_fpga, api_o_tgt_reg,
           api_o_tgt_cmd, api_o_src_reg, api_o_src_cmd, api_o_data
  );

endinterface

// File: rtl/se_api_reg_responder_regfile.sv
// Register file: writable array, read-only status overlay on the low indices,
// and a one-cycle pulse for every register that takes a write.
module se_api_regfile
  import se_api_reg_responder_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int RO_REGS  = 1,
  localparam int IDX_W   = $clog2(NUM_REGS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_en,
  input  logic [IDX_W-1:0]                  idx,
  input  logic [C_LENGTH_DATA-1:0]          wr_data,
  input  logic [RO_REGS*C_LENGTH_DATA-1:0]  status_in,
  output logic [C_LENGTH_DATA-1:0]          rd_data,
  output logic [NUM_REGS*C_LENGTH_DATA-1:0] regs_out,
  output logic [NUM_REGS-1:0]               wr_pulse
);

  logic [C_LENGTH_DATA-1:0] regs_q [NUM_REGS];
  logic                     writable;

  assign writable = 32'(idx) >= RO_REGS;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      if (wr_en && writable) begin
        regs_q[idx]   <= wr_data;
        wr_pulse[idx] <= 1'b1;
      end
    end
  end

  // Read-only indices return live status rather than stored contents
  always_comb begin
    rd_data = regs_q[idx];
    for (int k = 0; k < RO_REGS; k++) begin
      if (32'(idx) == k) rd_data = status_in[k*C_LENGTH_DATA +: C_LENGTH_DATA];
    end
  end

  always_comb begin
    regs_out = '0;
    for (int i = RO_REGS; i < NUM_REGS; i++) regs_out[i*C_LENGTH_DATA +: C_LENGTH_DATA] = regs_q[i];
  end

endmodule

// File: rtl/se_api_reg_responder.sv
// Pops API request messages, executes register writes/reads against the local
// register file and returns read data as a response message.
module se_api_reg_responder
  import se_api_reg_responder_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int RO_REGS  = 1
) (
  input  logic                              api_clk_in,
  input  logic                              api_rst_in,
  output logic                              api_o_clk_out,
  output logic                              api_i_clk_out,
  se_api_reg_responder_if.slave             api,
  input  logic [RO_REGS*C_LENGTH_DATA-1:0]  status_in,
  output logic [NUM_REGS*C_LENGTH_DATA-1:0] regs_out,
  output logic [NUM_REGS-1:0]               reg_wr_pulse_out,
  output logic [15:0]                       err_cnt_out
);

  localparam int IDX_W = $clog2(NUM_REGS);

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

  state_t                   state;
  api_msg_t                 req;
  logic [IDX_W-1:0]         idx;
  logic                     is_wr;
  logic                     is_rd;
  logic                     writable;
  logic                     rf_wr;
  logic [C_LENGTH_DATA-1:0] rd_data;
  logic [15:0]              err_cnt;

  logic [C_LENGTH_SLOT-1:0] resp_tgt_slot;
  logic [C_LENGTH_FPGA-1:0] resp_tgt_fpga;
  logic [C_LENGTH_REG-1:0]  resp_tgt_reg;
  logic [C_LENGTH_CMD-1:0]  resp_tgt_cmd;
  logic [C_LENGTH_REG-1:0]  resp_src_reg;
  logic [C_LENGTH_CMD-1:0]  resp_src_cmd;
  logic [C_LENGTH_DATA-1:0] resp_data;

  assign api_o_clk_out = api_clk_in;
  assign api_i_clk_out = api_clk_in;

  assign idx      = req.tgt_reg[IDX_W-1:0];
  assign is_wr    = req.tgt_cmd == CMD_REG_WR;
  assign is_rd    = req.tgt_cmd == CMD_REG_RD;
  assign writable = 32'(idx) >= RO_REGS;
  assign rf_wr    = (state == ST_EXEC) && is_wr && writable;

  se_api_regfile #(
    .NUM_REGS (NUM_REGS),
    .RO_REGS  (RO_REGS)
  ) u_regfile (
    .clk       (api_clk_in),
    .rst       (api_rst_in),
    .wr_en     (rf_wr),
    .idx       (idx),
    .wr_data   (req.data),
    .status_in (status_in),
    .rd_data   (rd_data),
    .regs_out  (regs_out),
    .wr_pulse  (reg_wr_pulse_out)
  );

  // Strobes are gated by reset so a pending pop or response is never issued into a reset edge
  assign api.api_i_rd_en = (state == ST_IDLE) && !api.api_i_empty && !api_rst_in;
  assign api.api_o_wr_en = (state == ST_RESP) && api.api_o_rfd && !api_rst_in;

  always_ff @(posedge api_clk_in) begin
    if (api_rst_in) begin
      state         <= ST_IDLE;
      req           <= '0;
      err_cnt       <= '0;
      resp_tgt_slot <= '0;
      resp_tgt_fpga <= '0;
      resp_tgt_reg  <= '0;
      resp_tgt_cmd  <= '0;
      resp_src_reg  <= '0;
      resp_src_cmd  <= '0;
      resp_data     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!api.api_i_empty) begin
            req <= '{src_slot: api.api_i_src_slot, src_fpga: api.api_i_src_fpga,
                     src_reg:  api.api_i_src_reg,  src_cmd:  api.api_i_src_cmd,
                     tgt_reg:  api.api_i_tgt_reg,  tgt_cmd:  api.api_i_tgt_cmd,
                     data:     api.api_i_data};
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          state <= ST_IDLE;
          if (is_rd) begin
            resp_tgt_slot <= req.src_slot;
            resp_tgt_fpga <= req.src_fpga;
            resp_tgt_reg  <= req.src_reg;
            resp_tgt_cmd  <= req.src_cmd;
            resp_src_reg  <= req.tgt_reg;
            resp_src_cmd  <= CMD_REG_RESP;
            resp_data     <= rd_data;
            state         <= ST_RESP;
          end else if (!(is_wr && writable)) begin
            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
          end
        end
        ST_RESP: begin
          if (api.api_o_rfd) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign api.api_o_tgt_slot = resp_tgt_slot;
  assign api.api_o_tgt_fpga = resp_tgt_fpga;
  assign api.api_o_tgt_reg  = resp_tgt_reg;
  assign api.api_o_tgt_cmd  = resp_tgt_cmd;
  assign api.api_o_src_reg  = resp_src_reg;
  assign api.api_o_src_cmd  = resp_src_cmd;
  assign api.api_o_data     = resp_data;
  assign err_cnt_out        = err_cnt;

endmodule

// File: tb/tb_se_api_reg_responder.sv
// Bench for se_api_reg_responder: a FWFT FIFO model feeds directed messages and a
// transaction-level register/response model is compared against the DUT every cycle.
module tb_se_api_reg_responder;
  import se_api_reg_responder_pkg::*;

  localparam int NR = 16;
  localparam int RO = 1;
  localparam int D  = C_LENGTH_DATA;

  typedef struct {
    logic [C_LENGTH_SLOT-1:0] tgt_slot;
    logic [C_LENGTH_FPGA-1:0] tgt_fpga;
    logic [C_LENGTH_REG-1:0]  tgt_reg;
    logic [C_LENGTH_CMD-1:0]  tgt_cmd;
    logic [C_LENGTH_REG-1:0]  src_reg;
    logic [D-1:0]             data;
    int                       ready;
  } exp_resp_t;

  logic clk = 1'b0;
  logic rst;
  logic o_clk, i_clk;
  logic [RO*D-1:0] status;
  logic [NR*D-1:0] regs;
  logic [NR-1:0]   pulse;
  logic [15:0]     err;

  always #5 clk = ~clk;

  se_api_reg_responder_if api ();

  se_api_reg_responder #(
    .NUM_REGS (NR),
    .RO_REGS  (RO)
  ) dut (
    .api_clk_in       (clk),
    .api_rst_in       (rst),
    .api_o_clk_out    (o_clk),
    .api_i_clk_out    (i_clk),
    .api              (api),
    .status_in        (status),
    .regs_out         (regs),
    .reg_wr_pulse_out (pulse),
    .err_cnt_out      (err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  api_msg_t  fifo_q[$];
  int        pops_req  = 0;
  int        pops_done = 0;
  int        pop_cyc[$];

  // Transaction-level model state
  logic [D-1:0] mregs [NR];
  logic [15:0]  merr = '0;
  logic         pend_valid = 1'b0;
  logic         pend_err;
  int           pend_due;
  int           pend_idx;
  logic [D-1:0] pend_data;
  exp_resp_t    exp_resp[$];
  int           cyc = 0;
  logic         rst_prev = 1'b0;
  int           resp_count = 0;

  logic [C_LENGTH_SLOT-1:0] last_tgt_slot;
  logic [C_LENGTH_FPGA-1:0] last_tgt_fpga;
  logic [C_LENGTH_REG-1:0]  last_tgt_reg;
  logic [C_LENGTH_CMD-1:0]  last_tgt_cmd;
  logic [C_LENGTH_REG-1:0]  last_src_reg;
  logic [C_LENGTH_CMD-1:0]  last_src_cmd;
  logic [D-1:0]             last_data;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic apply_stimulus(input int slot, input int fpga, input int src_reg, input int src_cmd,
                                input int tgt_reg, input logic [C_LENGTH_CMD-1:0] cmd, input logic [D-1:0] data);
    api_msg_t m;
    m.src_slot = C_LENGTH_SLOT'(slot);
    m.src_fpga = C_LENGTH_FPGA'(fpga);
    m.src_reg  = C_LENGTH_REG'(src_reg);
    m.src_cmd  = C_LENGTH_CMD'(src_cmd);
    m.tgt_reg  = C_LENGTH_REG'(tgt_reg);
    m.tgt_cmd  = cmd;
    m.data     = data;
    fifo_q.push_back(m);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (fifo_q.size() == 0 && pops_done == pops_req && !pend_valid && exp_resp.size() == 0) break;
      step(1);
    end
    if (i == budget) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL wait_idle: got busy after %0d cycles expected idle", budget);
    end
  endtask

  // FWFT FIFO: pops requested at a negedge take effect just after the next rising edge
  initial begin
    api.api_i_empty    = 1'b1;
    api.api_i_src_slot = '0;
    api.api_i_src_fpga = '0;
    api.api_i_src_reg  = '0;
    api.api_i_src_cmd  = '0;
    api.api_i_tgt_reg  = '0;
    api.api_i_tgt_cmd  = '0;
    api.api_i_data     = '0;
    forever begin
      @(posedge clk);
      #1;
      while (pops_done < pops_req && fifo_q.size() > 0) begin
        void'(fifo_q.pop_front());
        pops_done++;
      end
      if (fifo_q.size() > 0) begin
        api.api_i_empty    = 1'b0;
        api.api_i_src_slot = fifo_q[0].src_slot;
        api.api_i_src_fpga = fifo_q[0].src_fpga;
        api.api_i_src_reg  = fifo_q[0].src_reg;
        api.api_i_src_cmd  = fifo_q[0].src_cmd;
        api.api_i_tgt_reg  = fifo_q[0].tgt_reg;
        api.api_i_tgt_cmd  = fifo_q[0].tgt_cmd;
        api.api_i_data     = fifo_q[0].data;
      end else begin
        api.api_i_empty = 1'b1;
      end
    end
  end

  // Per-cycle compare against the model
  initial begin
    logic [NR-1:0] exp_pulse;
    logic          busy;
    api_msg_t      m;
    exp_resp_t     e;
    int            idx;
    for (int i = 0; i < NR; i++) mregs[i] = '0;
    forever begin
      @(negedge clk);
      cyc++;
      exp_pulse = '0;
      if (rst_prev) begin
        for (int i = 0; i < NR; i++) mregs[i] = '0;
        merr       = '0;
        pend_valid = 1'b0;
        exp_resp.delete();
      end
      if (pend_valid && cyc == pend_due) begin
        pend_valid = 1'b0;
        if (pend_err) begin
          if (merr != 16'hFFFF) merr = merr + 16'd1;
        end else begin
          mregs[pend_idx]     = pend_data;
          exp_pulse[pend_idx] = 1'b1;
        end
      end
      busy = pend_valid || (exp_resp.size() > 0);

      check_output("clk_fwd", {30'd0, o_clk, i_clk}, {30'd0, clk, clk});
      for (int i = 0; i < NR; i++) check_output($sformatf("reg%0d", i), regs[i*D +: D], mregs[i]);
      check_output("wr_pulse", 32'(pulse), 32'(exp_pulse));
      check_output("err_cnt", 32'(err), 32'(merr));

      if (exp_resp.size() > 0 && cyc >= exp_resp[0].ready) begin
        e = exp_resp[0];
        check_output("resp_tgt_slot", 32'(api.api_o_tgt_slot), 32'(e.tgt_slot));
        check_output("resp_tgt_fpga", 32'(api.api_o_tgt_fpga), 32'(e.tgt_fpga));
        check_output("resp_tgt_reg", 32'(api.api_o_tgt_reg), 32'(e.tgt_reg));
        check_output("resp_tgt_cmd", 32'(api.api_o_tgt_cmd), 32'(e.tgt_cmd));
        check_output("resp_src_reg", 32'(api.api_o_src_reg), 32'(e.src_reg));
        check_output("resp_src_cmd", 32'(api.api_o_src_cmd), 32'(CMD_REG_RESP));
        check_output("resp_data", api.api_o_data, e.data);
        check_output("resp_wr_en", 32'(api.api_o_wr_en), 32'(api.api_o_rfd && !rst));
        if (api.api_o_wr_en === 1'b1) begin
          resp_count++;
          last_tgt_slot = api.api_o_tgt_slot;
          last_tgt_fpga = api.api_o_tgt_fpga;
          last_tgt_reg  = api.api_o_tgt_reg;
          last_tgt_cmd  = api.api_o_tgt_cmd;
          last_src_reg  = api.api_o_src_reg;
          last_src_cmd  = api.api_o_src_cmd;
          last_data     = api.api_o_data;
          void'(exp_resp.pop_front());
        end
      end else begin
        check_output("idle_wr_en", 32'(api.api_o_wr_en), 32'd0);
      end

      check_output("rd_en", 32'(api.api_i_rd_en), 32'(!api.api_i_empty && !rst && !busy));
      if (api.api_i_rd_en === 1'b1 && api.api_i_empty === 1'b0 && fifo_q.size() > 0) begin
        m = fifo_q[0];
        pops_req++;
        pop_cyc.push_back(cyc);
        idx = int'(m.tgt_reg) % NR;
        if (m.tgt_cmd == CMD_REG_RD) begin
          e.tgt_slot = m.src_slot;
          e.tgt_fpga = m.src_fpga;
          e.tgt_reg  = m.src_reg;
          e.tgt_cmd  = m.src_cmd;
          e.src_reg  = m.tgt_reg;
          e.data     = (idx < RO) ? status[idx*D +: D] : mregs[idx];
          e.ready    = cyc + 2;
          exp_resp.push_back(e);
        end else begin
          pend_valid = 1'b1;
          pend_due   = cyc + 2;
          pend_idx   = idx;
          pend_data  = m.data;
          pend_err   = (m.tgt_cmd != CMD_REG_WR) || (idx < RO);
        end
      end
      rst_prev = rst;
    end
  end

  initial begin
    int rc;
    rst           = 1'b1;
    api.api_o_rfd = 1'b1;
    status        = 32'hCAFE;
    step(3);
    rst = 1'b0;

    // Reset state
    check_output("rst_regs_any", 32'(|regs), 32'd0);
    check_output("rst_err", 32'(err), 32'd0);
    check_output("rst_pulse", 32'(pulse), 32'd0);
    check_output("rst_o_data", api.api_o_data, 32'd0);
    check_output("rst_o_tgt_reg", 32'(api.api_o_tgt_reg), 32'd0);
    check_output("rst_wr_en", 32'(api.api_o_wr_en), 32'd0);
    check_output("rst_rd_en", 32'(api.api_i_rd_en), 32'd0);

    // Write reg 3
    apply_stimulus(2, 5, 0, 0, 3, CMD_REG_WR, 32'h1234);
    wait_idle(50);
    check_output("t1_reg3", regs[3*D +: D], 32'h1234);
    check_output("t1_no_resp", 32'(resp_count), 32'd0);

    // Read reg 3 back
    apply_stimulus(2, 5, 7, 9, 3, CMD_REG_RD, 32'h0);
    wait_idle(50);
    check_output("t2_count", 32'(resp_count), 32'd1);
    check_output("t2_tgt_slot", 32'(last_tgt_slot), 32'd2);
    check_output("t2_tgt_fpga", 32'(last_tgt_fpga), 32'd5);
    check_output("t2_tgt_reg", 32'(last_tgt_reg), 32'd7);
    check_output("t2_tgt_cmd", 32'(last_tgt_cmd), 32'd9);
    check_output("t2_src_reg", 32'(last_src_reg), 32'd3);
    check_output("t2_src_cmd", 32'(last_src_cmd), 32'd2);
    check_output("t2_data", last_data, 32'h1234);

    // Read status reg with rfd held low
    api.api_o_rfd = 1'b0;
    rc = resp_count;
    apply_stimulus(1, 1, 4, 4, 0, CMD_REG_RD, 32'h0);
    step(8);
    check_output("t3_held", 32'(resp_count - rc), 32'd0);
    api.api_o_rfd = 1'b1;
    wait_idle(50);
    check_output("t3_count", 32'(resp_count - rc), 32'd1);
    check_output("t3_data", last_data, 32'hCAFE);

    // Write to read-only reg and an unknown command
    rc = resp_count;
    apply_stimulus(3, 3, 0, 0, 0, CMD_REG_WR, 32'hBEEF);
    apply_stimulus(3, 3, 0, 0, 4, 8'd7, 32'hDEAD);
    wait_idle(50);
    check_output("t4_err", 32'(err), 32'd2);
    check_output("t4_reg0", regs[0 +: D], 32'd0);
    check_output("t4_reg4", regs[4*D +: D], 32'd0);
    check_output("t4_no_resp", 32'(resp_count - rc), 32'd0);

    // Back-to-back writes with index wrap
    pop_cyc.delete();
    apply_stimulus(0, 0, 0, 0, 1, CMD_REG_WR, 32'h11);
    apply_stimulus(0, 0, 0, 0, 2, CMD_REG_WR, 32'h22);
    apply_stimulus(0, 0, 0, 0, 17, CMD_REG_WR, 32'h33);
    apply_stimulus(0, 0, 0, 0, 31, CMD_REG_WR, 32'h44);
    wait_idle(50);
    check_output("t5_pops", 32'(pop_cyc.size()), 32'd4);
    if (pop_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++) check_output($sformatf("t5_gap%0d", i), 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd2);
    end
    check_output("t5_reg1", regs[1*D +: D], 32'h33);
    check_output("t5_reg2", regs[2*D +: D], 32'h22);
    check_output("t5_reg15", regs[15*D +: D], 32'h44);

    // Reset while a response is pending
    api.api_o_rfd = 1'b0;
    rc = resp_count;
    apply_stimulus(6, 6, 1, 1, 2, CMD_REG_RD, 32'h0);
    step(6);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    check_output("t6_regs_any", 32'(|regs), 32'd0);
    check_output("t6_err", 32'(err), 32'd0);
    check_output("t6_o_data", api.api_o_data, 32'd0);
    check_output("t6_o_src_reg", 32'(api.api_o_src_reg), 32'd0);
    step(3);
    api.api_o_rfd = 1'b1;
    step(2);
    check_output("t6_no_resp", 32'(resp_count - rc), 32'd0);
    apply_stimulus(1, 2, 0, 0, 5, CMD_REG_WR, 32'h55);
    wait_idle(50);
    check_output("t6_reg5", regs[5*D +: D], 32'h55);
    check_output("t6_reg2", regs[2*D +: D], 32'd0);
    check_output("t6_no_resp2", 32'(resp_count - rc), 32'd0);

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
